// File: rtl/tx_byte_buffer.sv
// tx_byte_buffer: FIFO between the DNN output and the UART Sender, launching one byte per frame with start-timeout retry.
module tx_byte_buffer #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int START_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        inData,
  input  logic              inValid,
  output logic              inFull,
  output logic [7:0]        outData,
  output logic              outTransmit,
  input  logic              senderBusy,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;
  state_t state, stateNext;
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;
  logic [TW-1:0] timer, timerNext;
  logic [ADDR_W:0] countNext;
  logic full, pop, push;
  assign full = count == (ADDR_W + 1)'(DEPTH);
  assign pop = state == IDLE && count != '0 && !senderBusy;
  // a pop frees a slot in the same cycle, so a write at full is still accepted
  assign push = inValid && (!full || pop);
  assign countNext = count + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
  assign outTransmit = state == LAUNCH;
  always_comb begin
    stateNext = state;
    timerNext = timer;
    unique case (state)
      IDLE: stateNext = pop ? LAUNCH : IDLE;
      LAUNCH: begin
        stateNext = WAIT_START;
        timerNext = '0;
      end
      WAIT_START: begin
        timerNext = senderBusy ? timer : timer + 1'b1;
        stateNext = senderBusy ? WAIT_DONE : (timer == TW'(START_TIMEOUT - 1) ? LAUNCH : WAIT_START);
      end
      WAIT_DONE: stateNext = senderBusy ? WAIT_DONE : IDLE;
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push && !reset) mem[wrPtr] <= inData;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      inFull <= 1'b0;
      overflow <= 1'b0;
      outData <= 8'h00;
    end else begin
      state <= stateNext;
      timer <= timerNext;
      count <= countNext;
      inFull <= countNext == (ADDR_W + 1)'(DEPTH);
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
        outData <= mem[rdPtr];
      end
      if (inValid && !push) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tx_byte_buffer.sv
// tb_tx_byte_buffer: scenario tasks against a Sender model and a launch log compared to expected byte order.
module tb_tx_byte_buffer;
  logic clk = 0;
  logic reset = 1;
  logic [7:0] inData = 0;
  logic inValid = 0;
  logic inFull, outTransmit, overflow;
  logic [7:0] outData;
  logic [4:0] count;
  logic senderBusy = 0;

  int total = 0, bad = 0;
  int cyc = 0;
  int frameLen = 10;
  bit stall = 0, ignoreStrobes = 0;
  int busyCnt = 0;
  int earlyLaunch = 0;
  logic [7:0] launchQ[$];
  int launchCyc[$];

  tx_byte_buffer dut (
    .clk(clk), .reset(reset), .inData(inData), .inValid(inValid), .inFull(inFull),
    .outData(outData), .outTransmit(outTransmit), .senderBusy(senderBusy),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sender: busy for frameLen cycles starting the cycle after an accepted strobe
  always @(posedge clk) begin
    if (stall) senderBusy <= 1;
    else if (busyCnt > 1) busyCnt <= busyCnt - 1;
    else if (busyCnt == 1) begin busyCnt <= 0; senderBusy <= 0; end
    else if (outTransmit && !ignoreStrobes) begin busyCnt <= frameLen; senderBusy <= 1; end
    else senderBusy <= 0;
  end

  always @(negedge clk)
    if (outTransmit) begin
      launchQ.push_back(outData);
      launchCyc.push_back(cyc);
      if (senderBusy) earlyLaunch++;
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick;
  endtask

  task automatic doReset;
    stall = 0;
    ignoreStrobes = 0;
    inValid = 0;
    for (int k = 0; k < 200 && senderBusy; k++) tick;
    reset = 1;
    tick;
    reset = 0;
    launchQ.delete();
    launchCyc.delete();
    earlyLaunch = 0;
  endtask

  task automatic writeByte(input logic [7:0] b);
    inValid = 1;
    inData = b;
    tick;
    inValid = 0;
  endtask

  task automatic waitLaunches(input int n, input int budget);
    int k = 0;
    while (launchQ.size() < n && k < budget) begin tick; k++; end
    total++;
    if (launchQ.size() < n) begin
      bad++;
      $display("FAIL launch_wait: got %0d launches, need %0d", launchQ.size(), n);
    end
  endtask

  task automatic test_reset;
    doReset;
    total += 5;
    if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    if (inFull !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", inFull); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    if (outTransmit !== 1'b0) begin bad++; $display("FAIL reset_tx: got %b want 0", outTransmit); end
    if (outData !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", outData); end
  endtask

  task automatic test_single_byte;
    int wrCyc;
    doReset;
    frameLen = 10;
    wrCyc = cyc;
    writeByte(8'hA5);
    total++;
    if (count !== 5'd1) begin bad++; $display("FAIL single_count1: got %0d want 1", count); end
    tick;
    total++;
    if (count !== 5'd0) begin bad++; $display("FAIL single_count0: got %0d want 0", count); end
    settle(20);
    total++;
    if (launchQ.size() != 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", launchQ.size()); end
    else begin
      total += 2;
      if (launchQ[0] !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", launchQ[0]); end
      if (launchCyc[0] != wrCyc + 2) begin bad++; $display("FAIL single_latency: got %0d want %0d", launchCyc[0] - wrCyc, 2); end
    end
  endtask

  task automatic test_burst;
    int peak = 0;
    doReset;
    frameLen = 6;
    for (int i = 1; i <= 5; i++) begin
      writeByte(8'(i));
      if (int'(count) > peak) peak = int'(count);
    end
    waitLaunches(5, 200);
    settle(10);
    total += 3;
    if (launchQ.size() != 5) begin bad++; $display("FAIL burst_count: got %0d want 5", launchQ.size()); end
    if (earlyLaunch != 0) begin bad++; $display("FAIL burst_busy: got %0d launches while busy want 0", earlyLaunch); end
    if (peak < 4 || peak > 5) begin bad++; $display("FAIL burst_peak: got %0d want 4..5", peak); end
    for (int i = 0; i < 5 && i < launchQ.size(); i++) begin
      total++;
      if (launchQ[i] !== 8'(i + 1)) begin bad++; $display("FAIL burst_order[%0d]: got %h want %h", i, launchQ[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_overflow;
    doReset;
    frameLen = 3;
    stall = 1;
    settle(2);
    for (int i = 0; i < 18; i++) begin
      writeByte(8'(8'h10 + i));
      if (i == 15) begin
        total += 3;
        if (count !== 5'd16) begin bad++; $display("FAIL ovf_count16: got %0d want 16", count); end
        if (inFull !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", inFull); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
      if (i == 16) begin
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
      end
    end
    total++;
    if (count !== 5'd16) begin bad++; $display("FAIL ovf_count_after: got %0d want 16", count); end
    stall = 0;
    waitLaunches(16, 400);
    settle(20);
    total += 2;
    if (launchQ.size() != 16) begin bad++; $display("FAIL ovf_sent: got %0d want 16", launchQ.size()); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    for (int i = 0; i < 16 && i < launchQ.size(); i++) begin
      total++;
      if (launchQ[i] !== 8'(8'h10 + i)) begin bad++; $display("FAIL ovf_order[%0d]: got %h want %h", i, launchQ[i], 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_pop_at_full;
    doReset;
    frameLen = 3;
    stall = 1;
    settle(2);
    for (int i = 0; i < 16; i++) writeByte(8'(8'h30 + i));
    total++;
    if (count !== 5'd16) begin bad++; $display("FAIL paf_pre: got %0d want 16", count); end
    stall = 0;
    for (int k = 0; k < 10 && senderBusy; k++) tick;
    writeByte(8'h40);
    total += 3;
    if (count !== 5'd16) begin bad++; $display("FAIL paf_count: got %0d want 16", count); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL paf_overflow: got %b want 0", overflow); end
    if (inFull !== 1'b1) begin bad++; $display("FAIL paf_full: got %b want 1", inFull); end
    waitLaunches(17, 600);
    settle(10);
    total++;
    if (launchQ.size() != 17) begin bad++; $display("FAIL paf_sent: got %0d want 17", launchQ.size()); end
    for (int i = 0; i < 17 && i < launchQ.size(); i++) begin
      total++;
      if (launchQ[i] !== (i == 16 ? 8'h40 : 8'(8'h30 + i))) begin
        bad++;
        $display("FAIL paf_order[%0d]: got %h want %h", i, launchQ[i], (i == 16 ? 8'h40 : 8'(8'h30 + i)));
      end
    end
  endtask

  task automatic test_retry;
    doReset;
    frameLen = 5;
    ignoreStrobes = 1;
    writeByte(8'h77);
    writeByte(8'h78);
    waitLaunches(1, 20);
    ignoreStrobes = 0;
    waitLaunches(2, 30);
    total += 3;
    if (launchQ.size() >= 2 && launchQ[1] !== 8'h77) begin bad++; $display("FAIL retry_data: got %h want 77", launchQ[1]); end
    if (launchQ.size() >= 2 && launchCyc[1] - launchCyc[0] != 9) begin bad++; $display("FAIL retry_gap: got %0d want 9", launchCyc[1] - launchCyc[0]); end
    if (count !== 5'd1) begin bad++; $display("FAIL retry_count_mid: got %0d want 1", count); end
    waitLaunches(3, 60);
    settle(15);
    total += 3;
    if (launchQ.size() != 3) begin bad++; $display("FAIL retry_total: got %0d want 3", launchQ.size()); end
    if (launchQ.size() >= 3 && launchQ[2] !== 8'h78) begin bad++; $display("FAIL retry_next: got %h want 78", launchQ[2]); end
    if (count !== 5'd0) begin bad++; $display("FAIL retry_count_end: got %0d want 0", count); end
  endtask

  task automatic test_reset_mid_frame;
    doReset;
    frameLen = 20;
    for (int i = 0; i < 4; i++) writeByte(8'(8'hA0 + i));
    for (int k = 0; k < 10 && !senderBusy; k++) tick;
    tick;
    total++;
    if (count !== 5'd3) begin bad++; $display("FAIL rmf_queued: got %0d want 3", count); end
    reset = 1;
    tick;
    reset = 0;
    total += 4;
    if (count !== 5'd0) begin bad++; $display("FAIL rmf_count: got %0d want 0", count); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL rmf_overflow: got %b want 0", overflow); end
    if (outTransmit !== 1'b0) begin bad++; $display("FAIL rmf_tx: got %b want 0", outTransmit); end
    if (inFull !== 1'b0) begin bad++; $display("FAIL rmf_full: got %b want 0", inFull); end
    settle(60);
    total++;
    if (launchQ.size() != 1) begin bad++; $display("FAIL rmf_quiet: got %0d launches want 1", launchQ.size()); end
    writeByte(8'h5C);
    waitLaunches(2, 40);
    total++;
    if (launchQ.size() >= 2 && launchQ[1] !== 8'h5C) begin bad++; $display("FAIL rmf_new: got %h want 5c", launchQ[1]); end
  endtask

  task automatic test_random;
    logic [7:0] expQ[$];
    logic [7:0] b;
    int n;
    for (int r = 0; r < 4; r++) begin
      doReset;
      expQ.delete();
      frameLen = $urandom_range(1, 8);
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        settle($urandom_range(0, 3));
        b = 8'($urandom);
        expQ.push_back(b);
        writeByte(b);
      end
      waitLaunches(n, 400);
      settle(frameLen + 5);
      total += 3;
      if (launchQ.size() != n) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", r, launchQ.size(), n); end
      if (count !== 5'd0) begin bad++; $display("FAIL rand%0d_drain: got %0d want 0", r, count); end
      if (earlyLaunch != 0) begin bad++; $display("FAIL rand%0d_busy: got %0d want 0", r, earlyLaunch); end
      for (int i = 0; i < n && i < launchQ.size(); i++) begin
        total++;
        if (launchQ[i] !== expQ[i]) begin bad++; $display("FAIL rand%0d_order[%0d]: got %h want %h", r, i, launchQ[i], expQ[i]); end
      end
    end
  endtask

  initial begin
    settle(2);
    test_overflow;
    test_reset;
    test_single_byte;
    test_burst;
    test_pop_at_full;
    test_retry;
    test_reset_mid_frame;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
